// File: rtl/rob.sv
// Circular reorder buffer, N-wide dispatch / CDB completion / head-window retire.
// Entries are flat vectors; field layout (LSB first): payload, branch_target,
// branch_taken, pred_target, pred_taken, branch, complete, rob_idx.
// Optional statistics outputs are enabled by defining ROB_STATS_EN.
`ifndef N
`define N 2
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif

module rob #(
  parameter int N      = `N,
  parameter int ROB_SZ = `ROB_SZ,
  parameter int ADDR_W = 32,
  parameter int PAY_W  = 16,
  localparam int IW    = $clog2(ROB_SZ),
  localparam int CW    = $clog2(ROB_SZ + 1),
  localparam int EW    = PAY_W + 2 * ADDR_W + 4 + IW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        disp_valid,
  input  logic [N*EW-1:0]     disp_entries,
  output logic                disp_stall,
  output logic [N*IW-1:0]     alloc_idx,
  output logic [CW-1:0]       free_slots,
  input  logic [N-1:0]        cdb_valid,
  input  logic [N*IW-1:0]     cdb_rob_idx,
  input  logic [N-1:0]        cdb_branch_taken,
  input  logic [N*ADDR_W-1:0] cdb_branch_target,
  output logic [N*EW-1:0]     head_entries,
  output logic [N-1:0]        head_valids,
`ifdef ROB_STATS_EN
  output logic [31:0]         stat_retired,
  output logic [31:0]         stat_full_cycles,
`endif
  input  logic                rob_mispredict
);

  localparam int BT_LSB  = PAY_W;
  localparam int BTK_BIT = BT_LSB + ADDR_W;
  localparam int PT_LSB  = BTK_BIT + 1;
  localparam int PTK_BIT = PT_LSB + ADDR_W;
  localparam int BR_BIT  = PTK_BIT + 1;
  localparam int CMP_BIT = BR_BIT + 1;
  localparam int IDX_LSB = CMP_BIT + 1;

  logic [EW-1:0]     r_ent [ROB_SZ];
  logic [ROB_SZ-1:0] r_valid;
  logic [IW-1:0]     r_head;
  logic [IW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [IW-1:0]     w_hidx [N];
  logic [IW-1:0]     w_aidx [N];
  logic [EW-1:0]     w_new_ent [N];
  logic [CW-1:0]     w_disp_cnt;
  logic [CW-1:0]     w_pop_cnt;
  logic [ROB_SZ-1:0] w_pop_mask;
  logic              w_run;
  logic              w_accept;

  assign free_slots = CW'(ROB_SZ) - r_count;
  assign disp_stall = (w_disp_cnt > free_slots);
  assign w_accept   = !disp_stall && !rob_mispredict;

  // Slot indices, dispatch count and the stored form of each dispatched entry.
  always_comb begin
    w_disp_cnt = '0;
    alloc_idx  = '0;
    for (int k = 0; k < N; k++) begin
      w_hidx[k] = r_head + IW'(k);
      w_aidx[k] = r_tail + IW'(k);
      alloc_idx[(N-1-k)*IW +: IW] = w_aidx[k];
      w_disp_cnt = w_disp_cnt + CW'(disp_valid[k]);
      // Branch outcome starts equal to the prediction so an incomplete
      // branch can never look mispredicted.
      w_new_ent[k] = disp_entries[(N-1-k)*EW +: EW];
      w_new_ent[k][IDX_LSB +: IW]   = w_aidx[k];
      w_new_ent[k][CMP_BIT]         = 1'b0;
      w_new_ent[k][BTK_BIT]         = w_new_ent[k][PTK_BIT];
      w_new_ent[k][BT_LSB +: ADDR_W] = w_new_ent[k][PT_LSB +: ADDR_W];
    end
  end

  // Head window and pop count: contiguous occupied+complete slots from the oldest.
  always_comb begin
    head_valids  = '0;
    head_entries = '0;
    w_pop_cnt    = '0;
    w_pop_mask   = '0;
    w_run        = 1'b1;
    for (int k = 0; k < N; k++) begin
      head_valids[N-1-k] = r_valid[w_hidx[k]];
      if (r_valid[w_hidx[k]]) head_entries[(N-1-k)*EW +: EW] = r_ent[w_hidx[k]];
      w_run = w_run & r_valid[w_hidx[k]] & r_ent[w_hidx[k]][CMP_BIT];
      if (w_run) begin
        w_pop_cnt = w_pop_cnt + CW'(1);
        w_pop_mask[w_hidx[k]] = 1'b1;
      end
    end
  end

  // Pointers, occupancy and valid bits; a mispredict flushes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (rob_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (CW'(k) < w_pop_cnt) r_valid[w_hidx[k]] <= 1'b0;
        if (w_accept && disp_valid[N-1-k]) r_valid[w_aidx[k]] <= 1'b1;
      end
      r_head <= r_head + IW'(w_pop_cnt);
      if (w_accept) r_tail <= r_tail + IW'(w_disp_cnt);
      r_count <= r_count + (w_accept ? w_disp_cnt : CW'(0)) - w_pop_cnt;
    end
  end

  // Entry payload storage: dispatch writes free slots, the CDB updates occupied ones.
  always_ff @(posedge clock) begin
    if (!rob_mispredict) begin
      for (int k = 0; k < N; k++) begin
        if (w_accept && disp_valid[N-1-k]) r_ent[w_aidx[k]] <= w_new_ent[k];
      end
      for (int k = 0; k < N; k++) begin
        if (cdb_valid[k] && r_valid[cdb_rob_idx[k*IW +: IW]] &&
            !w_pop_mask[cdb_rob_idx[k*IW +: IW]]) begin
          r_ent[cdb_rob_idx[k*IW +: IW]][CMP_BIT] <= 1'b1;
          if (r_ent[cdb_rob_idx[k*IW +: IW]][BR_BIT]) begin
            r_ent[cdb_rob_idx[k*IW +: IW]][BTK_BIT] <= cdb_branch_taken[k];
            r_ent[cdb_rob_idx[k*IW +: IW]][BT_LSB +: ADDR_W] <=
              cdb_branch_target[k*ADDR_W +: ADDR_W];
          end
        end
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_full;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating retire / stall counters; flushed entries are not counted as retired.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_retired <= '0;
      r_stat_full    <= '0;
    end else begin
      if (!rob_mispredict) r_stat_retired <= sat_add32(r_stat_retired, 32'(w_pop_cnt));
      r_stat_full <= sat_add32(r_stat_full, 32'(disp_stall));
    end
  end

  assign stat_retired     = r_stat_retired;
  assign stat_full_cycles = r_stat_full;
`endif

endmodule

// File: tb/tb_rob.sv
// Directed testbench for rob (N=2, ROB_SZ=32). Stats checks run when ROB_STATS_EN is defined.
module tb_rob;
  localparam int N = 2;
  localparam int SZ = 32;
  localparam int AW = 32;
  localparam int IW = 5;
  localparam int CW = 6;
  localparam int BT_LSB = 16;
  localparam int BTK_BIT = 48;
  localparam int PT_LSB = 49;
  localparam int PTK_BIT = 81;
  localparam int BR_BIT = 82;
  localparam int CMP_BIT = 83;
  localparam int IDX_LSB = 84;
  localparam int EW = 89;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    disp_valid = '0;
  logic [N*EW-1:0] disp_entries = '0;
  logic            disp_stall;
  logic [N*IW-1:0] alloc_idx;
  logic [CW-1:0]   free_slots;
  logic [N-1:0]    cdb_valid = '0;
  logic [N*IW-1:0] cdb_rob_idx = '0;
  logic [N-1:0]    cdb_branch_taken = '0;
  logic [N*AW-1:0] cdb_branch_target = '0;
  logic [N*EW-1:0] head_entries;
  logic [N-1:0]    head_valids;
  logic            rob_mispredict = 1'b0;
`ifdef ROB_STATS_EN
  logic [31:0]     stat_retired;
  logic [31:0]     stat_full_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rob #(.N(N), .ROB_SZ(SZ)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_entries(disp_entries),
    .disp_stall(disp_stall), .alloc_idx(alloc_idx), .free_slots(free_slots),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_branch_taken(cdb_branch_taken), .cdb_branch_target(cdb_branch_target),
    .head_entries(head_entries), .head_valids(head_valids),
`ifdef ROB_STATS_EN
    .stat_retired(stat_retired), .stat_full_cycles(stat_full_cycles),
`endif
    .rob_mispredict(rob_mispredict)
  );

  always #5 clock = ~clock;

  // Entry with deliberately wrong values in every field the ROB must override.
  function automatic logic [EW-1:0] mk(input logic [15:0] pay, input logic br,
                                       input logic ptk, input logic [31:0] ptgt);
    logic [EW-1:0] e;
    e = '0;
    e[15:0] = pay;
    e[BT_LSB +: AW] = 32'hDEAD_BEEF;
    e[BTK_BIT] = ~ptk;
    e[PT_LSB +: AW] = ptgt;
    e[PTK_BIT] = ptk;
    e[BR_BIT] = br;
    e[CMP_BIT] = 1'b1;
    e[IDX_LSB +: IW] = 5'h1F;
    return e;
  endfunction

  function automatic logic [EW-1:0] hent(input int s);
    return head_entries[s*EW +: EW];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    disp_valid = '0;
    cdb_valid = '0;
    rob_mispredict = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_disp(input logic [1:0] v, input logic [EW-1:0] e1, input logic [EW-1:0] e0);
    disp_valid = v;
    disp_entries = {e1, e0};
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [4:0] i1, input logic [4:0] i0);
    cdb_valid = v;
    cdb_rob_idx = {i1, i0};
    cdb_branch_taken = '0;
    cdb_branch_target = '0;
  endtask

  task automatic test_reset();
    n_cmp++; if (head_valids !== 2'b00) begin n_bad++; $display("FAIL rst_hv: got %b want 00", head_valids); end
    n_cmp++; if (head_entries !== '0) begin n_bad++; $display("FAIL rst_he: got %h want 0", head_entries); end
    n_cmp++; if (free_slots !== 6'd32) begin n_bad++; $display("FAIL rst_free: got %0d want 32", free_slots); end
    n_cmp++; if (alloc_idx !== {5'd0, 5'd1}) begin n_bad++; $display("FAIL rst_alloc: got %h want %h", alloc_idx, {5'd0, 5'd1}); end
    n_cmp++; if (disp_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", disp_stall); end
  endtask

  task automatic test_dispatch();
    set_disp(2'b11, mk(16'h1111, 1'b0, 1'b0, 32'h0), mk(16'h2222, 1'b0, 1'b0, 32'h0));
    #1;
    n_cmp++; if (alloc_idx !== {5'd0, 5'd1}) begin n_bad++; $display("FAIL disp_alloc: got %h want %h", alloc_idx, {5'd0, 5'd1}); end
    n_cmp++; if (disp_stall !== 1'b0) begin n_bad++; $display("FAIL disp_stall: got %b want 0", disp_stall); end
    step();
    disp_valid = '0;
    #1;
    n_cmp++; if (head_valids !== 2'b11) begin n_bad++; $display("FAIL disp_hv: got %b want 11", head_valids); end
    n_cmp++; if (free_slots !== 6'd30) begin n_bad++; $display("FAIL disp_free: got %0d want 30", free_slots); end
    n_cmp++; if (hent(1)[IDX_LSB +: IW] !== 5'd0) begin n_bad++; $display("FAIL disp_idx1: got %0d want 0", hent(1)[IDX_LSB +: IW]); end
    n_cmp++; if (hent(0)[IDX_LSB +: IW] !== 5'd1) begin n_bad++; $display("FAIL disp_idx0: got %0d want 1", hent(0)[IDX_LSB +: IW]); end
    n_cmp++; if (hent(1)[15:0] !== 16'h1111) begin n_bad++; $display("FAIL disp_pay1: got %h want 1111", hent(1)[15:0]); end
    n_cmp++; if ({hent(1)[CMP_BIT], hent(0)[CMP_BIT]} !== 2'b00) begin n_bad++; $display("FAIL disp_cmp: got %b want 00", {hent(1)[CMP_BIT], hent(0)[CMP_BIT]}); end
    n_cmp++; if (alloc_idx !== {5'd2, 5'd3}) begin n_bad++; $display("FAIL disp_alloc2: got %h want %h", alloc_idx, {5'd2, 5'd3}); end
  endtask

  task automatic test_complete_retire();
    set_cdb(2'b01, 5'd0, 5'd0);
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    n_cmp++; if (hent(1)[CMP_BIT] !== 1'b1 || hent(0)[CMP_BIT] !== 1'b0) begin n_bad++; $display("FAIL cr_cmp: got %b%b want 10", hent(1)[CMP_BIT], hent(0)[CMP_BIT]); end
    n_cmp++; if (free_slots !== 6'd30) begin n_bad++; $display("FAIL cr_free_a: got %0d want 30", free_slots); end
    step();
    n_cmp++; if (head_valids !== 2'b10) begin n_bad++; $display("FAIL cr_hv1: got %b want 10", head_valids); end
    n_cmp++; if (hent(1)[IDX_LSB +: IW] !== 5'd1) begin n_bad++; $display("FAIL cr_head1: got %0d want 1", hent(1)[IDX_LSB +: IW]); end
    n_cmp++; if (free_slots !== 6'd31) begin n_bad++; $display("FAIL cr_free_b: got %0d want 31", free_slots); end
    set_cdb(2'b10, 5'd1, 5'd0);
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    step();
    n_cmp++; if (head_valids !== 2'b00) begin n_bad++; $display("FAIL cr_hv2: got %b want 00", head_valids); end
    n_cmp++; if (free_slots !== 6'd32) begin n_bad++; $display("FAIL cr_free_c: got %0d want 32", free_slots); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) begin
      set_disp(2'b11, mk(16'(2*i), 1'b0, 1'b0, 32'h0), mk(16'(2*i+1), 1'b0, 1'b0, 32'h0));
      step();
    end
    set_disp(2'b10, mk(16'hBAD0, 1'b0, 1'b0, 32'h0), '0);
    #1;
    n_cmp++; if (disp_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %b want 1", disp_stall); end
    n_cmp++; if (free_slots !== 6'd0) begin n_bad++; $display("FAIL full_free: got %0d want 0", free_slots); end
    set_cdb(2'b01, 5'd0, 5'd0);
    step();
    disp_valid = '0;
    set_cdb(2'b00, 5'd0, 5'd0);
    n_cmp++; if (alloc_idx !== {5'd0, 5'd1}) begin n_bad++; $display("FAIL full_tail: got %h want %h", alloc_idx, {5'd0, 5'd1}); end
    n_cmp++; if (free_slots !== 6'd0) begin n_bad++; $display("FAIL full_free2: got %0d want 0", free_slots); end
    step();
    n_cmp++; if (free_slots !== 6'd1) begin n_bad++; $display("FAIL full_pop: got %0d want 1", free_slots); end
    set_disp(2'b10, mk(16'hA0A0, 1'b0, 1'b0, 32'h0), '0);
    #1;
    n_cmp++; if (disp_stall !== 1'b0 || alloc_idx[IW +: IW] !== 5'd0) begin n_bad++; $display("FAIL wrap_accept: got stall %b idx %0d want 0 0", disp_stall, alloc_idx[IW +: IW]); end
    step();
    disp_valid = '0;
    for (int i = 1; i < 30; i += 2) begin
      set_cdb(2'b11, 5'(i), 5'(i+1));
      step();
    end
    set_cdb(2'b00, 5'd0, 5'd0);
    repeat (4) step();
    n_cmp++; if (head_valids !== 2'b11) begin n_bad++; $display("FAIL wrap_hv: got %b want 11", head_valids); end
    n_cmp++; if (hent(1)[IDX_LSB +: IW] !== 5'd31 || hent(1)[15:0] !== 16'd31) begin n_bad++; $display("FAIL wrap_old: got idx %0d pay %h want 31 001f", hent(1)[IDX_LSB +: IW], hent(1)[15:0]); end
    n_cmp++; if (hent(0)[IDX_LSB +: IW] !== 5'd0 || hent(0)[15:0] !== 16'hA0A0) begin n_bad++; $display("FAIL wrap_new: got idx %0d pay %h want 0 a0a0", hent(0)[IDX_LSB +: IW], hent(0)[15:0]); end
    n_cmp++; if (free_slots !== 6'd30) begin n_bad++; $display("FAIL wrap_free: got %0d want 30", free_slots); end
    set_cdb(2'b11, 5'd31, 5'd0);
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    step();
    n_cmp++; if (head_valids !== 2'b00 || free_slots !== 6'd32) begin n_bad++; $display("FAIL wrap_pop2: got hv %b free %0d want 00 32", head_valids, free_slots); end
    n_cmp++; if (alloc_idx !== {5'd1, 5'd2}) begin n_bad++; $display("FAIL wrap_tail: got %h want %h", alloc_idx, {5'd1, 5'd2}); end
  endtask

  task automatic test_branch_mispredict();
    set_disp(2'b11, mk(16'h0B01, 1'b1, 1'b1, 32'h40), mk(16'h0B02, 1'b0, 1'b0, 32'h10));
    step();
    disp_valid = '0;
    n_cmp++; if (hent(1)[BTK_BIT] !== 1'b1 || hent(1)[BT_LSB +: AW] !== 32'h40) begin n_bad++; $display("FAIL br_pred: got %b %h want 1 40", hent(1)[BTK_BIT], hent(1)[BT_LSB +: AW]); end
    n_cmp++; if (hent(1)[CMP_BIT] !== 1'b0) begin n_bad++; $display("FAIL br_cmp0: got %b want 0", hent(1)[CMP_BIT]); end
    cdb_valid = 2'b11;
    cdb_rob_idx = {5'd1, 5'd0};
    cdb_branch_taken = 2'b11;
    cdb_branch_target = {32'h99, 32'h80};
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    n_cmp++; if (hent(1)[BT_LSB +: AW] !== 32'h80 || hent(1)[CMP_BIT] !== 1'b1) begin n_bad++; $display("FAIL br_res: got %h %b want 80 1", hent(1)[BT_LSB +: AW], hent(1)[CMP_BIT]); end
    n_cmp++; if (hent(0)[BT_LSB +: AW] !== 32'h10 || hent(0)[BTK_BIT] !== 1'b0 || hent(0)[CMP_BIT] !== 1'b1) begin n_bad++; $display("FAIL br_nonbr: got %h %b %b want 10 0 1", hent(0)[BT_LSB +: AW], hent(0)[BTK_BIT], hent(0)[CMP_BIT]); end
    rob_mispredict = 1'b1;
    set_disp(2'b11, mk(16'h0C01, 1'b0, 1'b0, 32'h0), mk(16'h0C02, 1'b0, 1'b0, 32'h0));
    step();
    rob_mispredict = 1'b0;
    disp_valid = '0;
    n_cmp++; if (head_valids !== 2'b00 || free_slots !== 6'd32) begin n_bad++; $display("FAIL br_flush: got hv %b free %0d want 00 32", head_valids, free_slots); end
    n_cmp++; if (alloc_idx !== {5'd0, 5'd1}) begin n_bad++; $display("FAIL br_tail: got %h want %h", alloc_idx, {5'd0, 5'd1}); end
  endtask

  task automatic test_back_to_back();
    set_disp(2'b11, mk(16'd0, 1'b0, 1'b0, 32'h0), mk(16'd1, 1'b0, 1'b0, 32'h0));
    step();
    set_disp(2'b11, mk(16'd2, 1'b0, 1'b0, 32'h0), mk(16'd3, 1'b0, 1'b0, 32'h0));
    step();
    set_disp(2'b10, mk(16'd4, 1'b0, 1'b0, 32'h0), '0);
    step();
    disp_valid = '0;
    set_cdb(2'b11, 5'd0, 5'd1);
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    n_cmp++; if (free_slots !== 6'd27) begin n_bad++; $display("FAIL b2b_pre: got %0d want 27", free_slots); end
    set_disp(2'b11, mk(16'd5, 1'b0, 1'b0, 32'h0), mk(16'd6, 1'b0, 1'b0, 32'h0));
    #1;
    n_cmp++; if (disp_stall !== 1'b0 || alloc_idx !== {5'd5, 5'd6}) begin n_bad++; $display("FAIL b2b_alloc: got stall %b idx %h want 0 %h", disp_stall, alloc_idx, {5'd5, 5'd6}); end
    step();
    disp_valid = '0;
    n_cmp++; if (free_slots !== 6'd27) begin n_bad++; $display("FAIL b2b_count: got %0d want 27", free_slots); end
    n_cmp++; if (hent(1)[IDX_LSB +: IW] !== 5'd2 || head_valids !== 2'b11) begin n_bad++; $display("FAIL b2b_head: got idx %0d hv %b want 2 11", hent(1)[IDX_LSB +: IW], head_valids); end
    n_cmp++; if (alloc_idx !== {5'd7, 5'd8}) begin n_bad++; $display("FAIL b2b_tail: got %h want %h", alloc_idx, {5'd7, 5'd8}); end
  endtask

  task automatic test_async_reset();
    set_disp(2'b11, mk(16'hEE00, 1'b0, 1'b0, 32'h0), mk(16'hEE01, 1'b0, 1'b0, 32'h0));
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (head_valids !== 2'b00 || free_slots !== 6'd32) begin n_bad++; $display("FAIL arst_state: got hv %b free %0d want 00 32", head_valids, free_slots); end
    n_cmp++; if (alloc_idx !== {5'd0, 5'd1} || disp_stall !== 1'b0) begin n_bad++; $display("FAIL arst_alloc: got %h stall %b want %h 0", alloc_idx, disp_stall, {5'd0, 5'd1}); end
    disp_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

`ifdef ROB_STATS_EN
  task automatic test_stats();
    n_cmp++; if (stat_retired !== 32'd0 || stat_full_cycles !== 32'd0) begin n_bad++; $display("FAIL st_rst: got %0d %0d want 0 0", stat_retired, stat_full_cycles); end
    for (int i = 0; i < 3; i++) begin
      set_disp(2'b11, mk(16'(i), 1'b0, 1'b0, 32'h0), mk(16'(i), 1'b0, 1'b0, 32'h0));
      step();
    end
    set_disp(2'b10, mk(16'd6, 1'b0, 1'b0, 32'h0), '0);
    step();
    disp_valid = '0;
    for (int i = 0; i < 3; i++) begin
      set_cdb(2'b11, 5'(2*i), 5'(2*i+1));
      step();
    end
    set_cdb(2'b01, 5'd0, 5'd6);
    step();
    set_cdb(2'b00, 5'd0, 5'd0);
    repeat (3) step();
    set_disp(2'b11, mk(16'h5, 1'b0, 1'b0, 32'h0), mk(16'h5, 1'b0, 1'b0, 32'h0));
    repeat (19) step();
    disp_valid = '0;
    n_cmp++; if (stat_retired !== 32'd7) begin n_bad++; $display("FAIL st_ret: got %0d want 7", stat_retired); end
    n_cmp++; if (stat_full_cycles !== 32'd3) begin n_bad++; $display("FAIL st_full: got %0d want 3", stat_full_cycles); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (stat_retired !== 32'd0 || stat_full_cycles !== 32'd0) begin n_bad++; $display("FAIL st_arst: got %0d %0d want 0 0", stat_retired, stat_full_cycles); end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_dispatch();
    test_complete_retire();
    do_reset();
    test_full_wrap();
    do_reset();
    test_branch_mispredict();
    do_reset();
    test_back_to_back();
    test_async_reset();
`ifdef ROB_STATS_EN
    do_reset();
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
